// File: rtl/ps2_frame_receiver_if.sv
// Bundle between the PS/2 receiver and its surroundings: debounced line levels
// in, received byte plus status strobes out.
interface ps2_frame_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       timeout_error;
  logic       busy;

  // The master drives the PS/2 line levels and consumes the decoded results.
  modport master (
    output ps2_clk, ps2_data,
    input  data_out, data_valid, parity_error, frame_error, timeout_error, busy
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output data_out, data_valid, parity_error, frame_error, timeout_error, busy
  );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: samples data on PS/2 clock falling edges,
// checks odd parity and the stop bit, and aborts stalled frames on timeout.
module ps2_frame_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  ps2_frame_receiver_if.slave  bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          r_state;
  logic            r_clk_prev;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_par_bit;
  logic [TW-1:0]   r_timer;
  logic [7:0]      r_data_out;
  logic            r_data_valid;
  logic            r_parity_error;
  logic            r_frame_error;
  logic            r_timeout_error;
  logic            r_busy;

  logic            w_fall;
  logic            w_timeout;
  logic            w_ok_par;
  logic            w_ok_stop;

  // Odd parity over data plus parity bit must give an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ((^d) ^ p) == 1'b1;
  endfunction

  assign w_fall    = r_clk_prev & ~bus.ps2_clk;
  assign w_timeout = (r_state != S_IDLE) && (r_timer == TIMER_LAST) && !w_fall;
  assign w_ok_par  = odd_parity_ok(r_shift, r_par_bit);
  assign w_ok_stop = bus.ps2_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_clk_prev      <= 1'b1;
      r_bit_cnt       <= 3'd0;
      r_shift         <= 8'h00;
      r_par_bit       <= 1'b0;
      r_timer         <= '0;
      r_data_out      <= 8'h00;
      r_data_valid    <= 1'b0;
      r_parity_error  <= 1'b0;
      r_frame_error   <= 1'b0;
      r_timeout_error <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_clk_prev      <= bus.ps2_clk;
      r_data_valid    <= 1'b0;
      r_parity_error  <= 1'b0;
      r_frame_error   <= 1'b0;
      r_timeout_error <= 1'b0;

      if (r_state == S_IDLE || w_fall) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end

      // A fall in the final timer cycle wins, since w_timeout excludes it.
      if (w_timeout) begin
        r_state         <= S_IDLE;
        r_busy          <= 1'b0;
        r_bit_cnt       <= 3'd0;
        r_timer         <= '0;
        r_timeout_error <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!bus.ps2_data) begin
              r_state   <= S_DATA;
              r_busy    <= 1'b1;
              r_bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            r_shift   <= {bus.ps2_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_par_bit <= bus.ps2_data;
            r_state   <= S_STOP;
          end
          S_STOP: begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_parity_error <= !w_ok_par;
            r_frame_error  <= !w_ok_stop;
            if (w_ok_par && w_ok_stop) begin
              r_data_out   <= r_shift;
              r_data_valid <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out      = r_data_out;
  assign bus.data_valid    = r_data_valid;
  assign bus.parity_error  = r_parity_error;
  assign bus.frame_error   = r_frame_error;
  assign bus.timeout_error = r_timeout_error;
  assign bus.busy          = r_busy;

endmodule
